bounded_updown_counter: RTL and testbench
=========================================

# bounded_updown_counter

Parametrised bounded up/down counter: the next generation of the lab-2 saturating 4-bit counter, generalised in width and bounds, with programmable step and three limit modes (saturate, wrap, bounce). Sits in the lab counter datapath in place of the fixed 0..12 counter and drives the display/readout logic plus limit indicators. It keeps the existing clk/rst/en/dir/load/data control contract.

## Interface
- WIDTH, 4: counter width in bits.
- DATA_W, 6: load data width; may exceed WIDTH.
- MIN_VAL, 0: lower bound, inclusive.
- MAX_VAL, 12: upper bound, inclusive. Require MIN_VAL < MAX_VAL <= 2^WIDTH-1; violation is an elaboration error.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count/load enable; when 0, all state holds and load is ignored.
- load  in  1  with en=1, load `data` (clamped) instead of counting.
- data  in  DATA_W  load value.
- dir  in  1  1=up, 0=down.
- mode  in  2  00 saturate, 01 wrap, 10 bounce, 11 reserved (behaves as saturate).
- step  in  WIDTH  increment magnitude per enabled cycle.
- out  out  WIDTH  counter value, always in [MIN_VAL, MAX_VAL].
- dir_q  out  1  direction to be applied on the next count.
- at_max / at_min  out  1  combinational: out==MAX_VAL / out==MIN_VAL.
- tc  out  1  registered terminal-count pulse.
- err  out  1  sticky illegal-load flag; present only with BUDC_LOAD_CHECK_EN.

## Operation
- Priority each edge: rst > (en & load) > (en & count) > hold.
- Reset: out=MIN_VAL, dir_q=1, tc=0, err=0.
- Load: out = MAX_VAL if data>MAX_VAL, MIN_VAL if data<MIN_VAL, else data[WIDTH-1:0]. dir_q<=dir. tc=0.
- Count: effective step s = min(step, MAX_VAL-MIN_VAL). s=0 holds out and gives no tc. Intermediate sum/difference is computed in WIDTH+1 bits, with no truncation before the limit check.
- In saturate and wrap, the direction used is the dir input; dir_q<=dir.
- Saturate: a result past the limit is clamped to the limit. tc=1 when out changes and lands on the limit. Already at the limit means no change and tc=0.
- Wrap, up: if out+s>MAX_VAL, out = out+s-(MAX_VAL-MIN_VAL+1); down is mirrored. tc=1 on every wrap.
- Bounce: the direction used is dir_q, not dir. Up: with n=out+s, if n>=MAX_VAL then out=MAX_VAL-(n-MAX_VAL), dir_q<=0, tc=1. Down is mirrored at MIN_VAL. Reaching the limit exactly also reverses.
- Mode change takes effect on the next enabled edge; out is kept.
- Reset asserted mid-count or together with load always wins.

## Timing
- out, dir_q, tc and err update one edge after the sampled inputs (latency 1).
- tc is high for exactly the one cycle in which out shows the limit-event result.
- at_max/at_min follow out combinationally, with no extra latency.

## Configuration
- BUDC_LOAD_CHECK_EN defined: err port exists. It is set on any en&load with data outside [MIN_VAL, MAX_VAL] and cleared only by rst.
- Undefined: err port and logic are absent; clamping on load is unchanged.

## Structure
- Package bounded_counter_pkg holds MODE_SAT=2'b00, MODE_WRAP=2'b01, MODE_BOUNCE=2'b10 and a mode typedef.
- One sub-module, bounded_step_calc: combinational; inputs out, s, direction, mode; outputs next value, limit-hit and reverse flags. The top owns the registers, load clamp and err.

## Test plan (defaults WIDTH=4, MIN=0, MAX=12)
- rst, then en=1 dir=1 mode=SAT step=1 for 14 cycles -> out 1..12 then holds 12; single tc pulse on reaching 12; at_max=1.
- en=1 load=1 data=40 -> out=12, err=1. Later load data=5 -> out=5, err stays 1 until rst.
- WRAP, out=11, step=3 up -> out=1, tc=1; next edge -> out=4, tc=0.
- BOUNCE, out=10, step=3, dir_q=1 -> out=11, dir_q=0; next edge -> out=8.
- SAT down from out=2, step=3 -> out=0, tc=1; next edge -> out=0, tc=0. step=0 or en=0 holds out.
- rst=1 with en=1 load=1 data=7 mid-count -> out=0, dir_q=1, tc=0.

Source files
------------

// File: rtl/bounded_counter_pkg.sv
// Shared mode encoding for the bounded up/down counter and its step calculator.
package bounded_counter_pkg;

  typedef enum logic [1:0] {
    MODE_SAT    = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

endpackage

// File: rtl/bounded_step_calc.sv
// Combinational next-value logic for one count step: saturate, wrap or bounce
// against [MIN_VAL, MAX_VAL]; all arithmetic is carried in WIDTH+1 bits.
module bounded_step_calc
  import bounded_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 12
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] s,
  input  logic             up,
  input  mode_e            mode,
  output logic [WIDTH-1:0] nxt,
  output logic             hit,
  output logic             rev
);

  localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MIN_X   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   RANGE_X = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
  localparam logic [WIDTH:0]   TWO_MAX = (WIDTH+1)'(2 * MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);

  logic [WIDTH:0] cur_x, s_x, sum, diff, lo;

  assign cur_x = {1'b0, cur};
  assign s_x   = {1'b0, s};
  assign sum   = cur_x + s_x;
  assign diff  = cur_x - s_x;  // only meaningful when cur - s stays above MIN
  assign lo    = MIN_X + s_x;  // cur <= lo  <=>  cur - s <= MIN

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    nxt = cur;
    hit = 1'b0;
    rev = 1'b0;
    if (s != '0) begin
      case (mode)
        MODE_WRAP: begin
          if (up) begin
            if (sum > MAX_X) begin
              nxt = WIDTH'(sum - RANGE_X);
              hit = 1'b1;
            end else begin
              nxt = WIDTH'(sum);
            end
          end else if (cur_x < lo) begin
            nxt = WIDTH'(cur_x + RANGE_X - s_x);
            hit = 1'b1;
          end else begin
            nxt = WIDTH'(diff);
          end
        end
        MODE_BOUNCE: begin
          if (up) begin
            if (sum >= MAX_X) begin
              nxt = WIDTH'(TWO_MAX - sum);
              hit = 1'b1;
              rev = 1'b1;
            end else begin
              nxt = WIDTH'(sum);
            end
          end else if (cur_x <= lo) begin
            nxt = WIDTH'(lo + MIN_X - cur_x);
            hit = 1'b1;
            rev = 1'b1;
          end else begin
            nxt = WIDTH'(diff);
          end
        end
        default: begin
          // Saturate; the reserved encoding lands here as well.
          if (up) nxt = (sum >= MAX_X) ? MAX_W : WIDTH'(sum);
          else    nxt = (cur_x <= lo)  ? MIN_W : WIDTH'(diff);
          hit = (nxt != cur) && (nxt == (up ? MAX_W : MIN_W));
        end
      endcase
    end
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with saturate/wrap/bounce limits and clamped load.
// Define BUDC_LOAD_CHECK_EN to add the sticky err flag for out-of-range loads.
module bounded_updown_counter
  import bounded_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DATA_W  = 6,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  step,
  output logic [WIDTH-1:0]  out,
  output logic              dir_q,
  output logic              at_max,
  output logic              at_min,
  output logic              tc
`ifdef BUDC_LOAD_CHECK_EN
  ,
  output logic              err
`endif
);

  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2 ** WIDTH) - 1)) begin : g_bad_bounds
    $error("bounded_updown_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam int               CW    = ((DATA_W > WIDTH) ? DATA_W : WIDTH) + 1;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] SPAN  = WIDTH'(MAX_VAL - MIN_VAL);

  mode_e            mode_v;
  logic [WIDTH-1:0] s, nxt;
  logic             up, hit, rev;
  logic [CW-1:0]    data_x;
  logic             above, below;
  logic [WIDTH-1:0] load_val;

  assign mode_v = mode_e'(mode);
  assign s      = (step > SPAN) ? SPAN : step;
  assign up     = (mode_v == MODE_BOUNCE) ? dir_q : dir;

  assign data_x   = CW'(data);
  assign above    = data_x > CW'(MAX_VAL);
  assign below    = data_x < CW'(MIN_VAL);
  assign load_val = above ? MAX_W : (below ? MIN_W : data_x[WIDTH-1:0]);

  bounded_step_calc #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_step (
    .cur (out),
    .s   (s),
    .up  (up),
    .mode(mode_v),
    .nxt (nxt),
    .hit (hit),
    .rev (rev)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= MIN_W;
      dir_q <= 1'b1;
      tc    <= 1'b0;
    end else if (en && load) begin
      out   <= load_val;
      dir_q <= dir;
      tc    <= 1'b0;
    end else if (en) begin
      out   <= nxt;
      tc    <= hit;
      if (mode_v == MODE_BOUNCE) dir_q <= rev ? ~dir_q : dir_q;
      else                       dir_q <= dir;
    end else begin
      tc    <= 1'b0;  // tc marks only the cycle that shows the limit event
    end
  end

`ifdef BUDC_LOAD_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                 err <= 1'b0;
    else if (en && load && (above || below)) err <= 1'b1;
  end
`endif

  assign at_max = (out == MAX_W);
  assign at_min = (out == MIN_W);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Self-checking bench: directed test-plan cases plus randomized traffic, all
// compared every cycle against an integer-arithmetic model of the counter.
module tb_bounded_updown_counter;

  localparam int W   = 4;
  localparam int DW  = 6;
  localparam int MIN = 0;
  localparam int MAX = 12;

  logic          clk = 1'b0;
  logic          rst, en, load, dir;
  logic [DW-1:0] data;
  logic [1:0]    mode;
  logic [W-1:0]  step;
  logic [W-1:0]  out;
  logic          dir_q, at_max, at_min, tc;
`ifdef BUDC_LOAD_CHECK_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;

  int m_out;
  bit m_dir, m_tc, m_err;

  always #5 clk = ~clk;

  bounded_updown_counter #(.WIDTH(W), .DATA_W(DW), .MIN_VAL(MIN), .MAX_VAL(MAX)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .data  (data),
    .dir   (dir),
    .mode  (mode),
    .step  (step),
    .out   (out),
    .dir_q (dir_q),
    .at_max(at_max),
    .at_min(at_min),
    .tc    (tc)
`ifdef BUDC_LOAD_CHECK_EN
    ,
    .err   (err)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules applied to the inputs sampled at this edge.
  task automatic model_step();
    int span, s, n, d;
    span = MAX - MIN;
    s    = (int'(step) < span) ? int'(step) : span;
    if (rst) begin
      m_out = MIN; m_dir = 1; m_tc = 0; m_err = 0;
    end else if (en && load) begin
      if (int'(data) > MAX || int'(data) < MIN) m_err = 1;
      m_out = (int'(data) > MAX) ? MAX : (int'(data) < MIN) ? MIN : int'(data);
      m_dir = dir;
      m_tc  = 0;
    end else if (en) begin
      m_tc = 0;
      if (mode == 2'b10) begin
        if (s != 0) begin
          if (m_dir) begin
            n = m_out + s;
            if (n >= MAX) begin n = 2 * MAX - n; m_dir = 0; m_tc = 1; end
          end else begin
            n = m_out - s;
            if (n <= MIN) begin n = 2 * MIN - n; m_dir = 1; m_tc = 1; end
          end
          m_out = n;
        end
      end else begin
        m_dir = dir;
        d = dir ? s : -s;
        n = m_out + d;
        if (s != 0 && mode == 2'b01) begin
          if (n > MAX)      begin n = n - (span + 1); m_tc = 1; end
          else if (n < MIN) begin n = n + (span + 1); m_tc = 1; end
          m_out = n;
        end else if (s != 0) begin
          if (n > MAX) n = MAX;
          if (n < MIN) n = MIN;
          m_tc  = (n != m_out) && (n == MAX || n == MIN);
          m_out = n;
        end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic compare_all();
    check("out",    int'(out),    m_out);
    check("dir_q",  int'(dir_q),  int'(m_dir));
    check("tc",     int'(tc),     int'(m_tc));
    check("at_max", int'(at_max), int'(m_out == MAX));
    check("at_min", int'(at_min), int'(m_out == MIN));
`ifdef BUDC_LOAD_CHECK_EN
    check("err",    int'(err),    int'(m_err));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_load(input int val, input logic d);
    en = 1; load = 1; data = DW'(val); dir = d;
    tick();
    load = 0;
  endtask

  initial begin
    rst = 1; en = 0; load = 0; data = '0; dir = 1; mode = 2'b00; step = '0;
    tick();
    tick();
    check("rst_out", int'(out), 0);
    check("rst_dir_q", int'(dir_q), 1);
    check("rst_tc", int'(tc), 0);
    check("rst_at_min", int'(at_min), 1);
    rst = 0;

    // Saturating count up: 1..12, then held, one tc pulse on arrival.
    en = 1; dir = 1; mode = 2'b00; step = 1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("sat_up_out", int'(out), (i < 12) ? i : 12);
      check("sat_up_tc", int'(tc), (i == 12) ? 1 : 0);
    end
    check("sat_up_at_max", int'(at_max), 1);

    // Out-of-range load clamps; legal load after it.
    do_load(40, 1);
    check("load40_out", int'(out), 12);
`ifdef BUDC_LOAD_CHECK_EN
    check("load40_err", int'(err), 1);
`endif
    do_load(5, 1);
    check("load5_out", int'(out), 5);
`ifdef BUDC_LOAD_CHECK_EN
    check("load5_err", int'(err), 1);
`endif

    // Wrap up past MAX.
    do_load(11, 1);
    mode = 2'b01; step = 3;
    tick();
    check("wrap_out", int'(out), 1);
    check("wrap_tc", int'(tc), 1);
    tick();
    check("wrap_out2", int'(out), 4);
    check("wrap_tc2", int'(tc), 0);

    // Bounce off MAX; dir input is ignored in bounce.
    do_load(10, 1);
    mode = 2'b10; step = 3; dir = 1;
    tick();
    check("bounce_out", int'(out), 11);
    check("bounce_dir_q", int'(dir_q), 0);
    tick();
    check("bounce_out2", int'(out), 8);

    // Saturate down onto MIN, then hold conditions.
    do_load(2, 0);
    mode = 2'b00; step = 3; dir = 0;
    tick();
    check("sat_dn_out", int'(out), 0);
    check("sat_dn_tc", int'(tc), 1);
    tick();
    check("sat_dn_out2", int'(out), 0);
    check("sat_dn_tc2", int'(tc), 0);
    do_load(6, 1);
    step = 0;
    tick();
    check("step0_hold", int'(out), 6);
    step = 2; en = 0;
    tick();
    check("en0_hold", int'(out), 6);

    // Reset beats a simultaneous load mid-count.
    en = 1; tick();
    rst = 1; load = 1; data = 7;
    tick();
    check("rst_load_out", int'(out), 0);
    check("rst_load_dir_q", int'(dir_q), 1);
    check("rst_load_tc", int'(tc), 0);
    rst = 0; load = 0;

    // Randomized traffic across all modes, steps and loads.
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) < 3);
      en   = ($urandom_range(0, 99) < 85);
      load = ($urandom_range(0, 99) < 12);
      data = DW'($urandom_range(0, 63));
      dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      step = W'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
